// File: rtl/mcp4726_i2c_wr_pkg.sv
// Shared types and MCP4726 command constants for the I2C DAC writer.
// Holds the FSM state encoding and the fast-write byte framing helper.
package mcp4726_i2c_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP
  } state_t;

  // Fast-write command: C2:C1 = 00, PD1:PD0 = 00 (normal operation)
  localparam logic [1:0] FW_CMD = 2'b00;
  localparam logic [1:0] FW_PD  = 2'b00;

  localparam logic [1:0] LAST_BYTE = 2'd2;

  function automatic logic [7:0] tx_byte(
    input logic [6:0]  adr,
    input logic [11:0] d,
    input logic [1:0]  idx
  );
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = {adr, 1'b0};
      2'd1:    b = {FW_CMD, FW_PD, d[11:8]};
      default: b = d[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mcp4726_i2c_wr_if.sv
// Sample/handshake and open-drain I2C line bundle for mcp4726_i2c_wr.
// slave: the DAC writer side; master: the host/bus side.
interface mcp4726_i2c_wr_if;

  logic [11:0] WAVEs_i;
  logic        REQ_i;
  logic        SDA_i;
  logic        SCL_o;
  logic        SDA_o;
  logic        BUSY_o;
  logic        DONE_o;
  logic        NACK_o;

  modport slave (
    input  WAVEs_i, REQ_i, SDA_i,
    output SCL_o, SDA_o, BUSY_o, DONE_o, NACK_o
  );

  modport master (
    output WAVEs_i, REQ_i, SDA_i,
    input  SCL_o, SDA_o, BUSY_o, DONE_o, NACK_o
  );

endinterface

// File: rtl/mcp4726_i2c_wr_qtic.sv
// Quarter-bit tick prescaler: TIC_o pulses every C_Q clocks while EN_i.
// Ports: CK_i, XARST_i (async low), EN_i, TIC_o.
module i2c_qtic #(
  parameter int C_F_CK  = 135_000_000,
  parameter int C_F_SCL = 400_000
) (
  input  logic CK_i,
  input  logic XARST_i,
  input  logic EN_i,
  output logic TIC_o
);

  localparam int C_QR = C_F_CK / (4 * C_F_SCL);
  localparam int C_Q  = (C_QR < 2) ? 2 : C_QR;
  localparam int W    = $clog2(C_Q);

  localparam logic [W-1:0] CNT_MAX = W'(C_Q - 1);

  logic [W-1:0] cnt;

  // Disabled means held at zero, so every START begins a fresh quarter
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      cnt <= '0;
    end else if (!EN_i || cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign TIC_o = EN_i && (cnt == CNT_MAX);

endmodule

// File: rtl/mcp4726_i2c_wr.sv
// MCP4726 fast-write I2C master: pushes 12-bit DDS samples to the DAC.
// Ports: CK_i, XARST_i (async low), bus (samples in, SCL/SDA/status out).
module mcp4726_i2c_wr
  import mcp4726_i2c_wr_pkg::*;
#(
  parameter int         C_F_CK    = 135_000_000,
  parameter int         C_F_SCL   = 400_000,
  parameter logic [6:0] C_DEV_ADR = 7'h60
) (
  input  logic              CK_i,
  input  logic              XARST_i,
  mcp4726_i2c_wr_if.slave   bus
);

  state_t      state, state_n;
  logic [1:0]  qtr, qtr_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [1:0]  byte_cnt, byte_n;
  logic [11:0] dat;
  logic [11:0] pend_val;
  logic        pend;
  logic        scl_q, sda_q;
  logic        scl_c, sda_c;
  logic        done_q, done_set;
  logic        nack_q, nack_set, nack_clr;
  logic        shf_ld;
  logic        busy;
  logic        tic;
  logic [7:0]  tx_b;
  logic        mid;

  assign busy = (state != ST_IDLE);
  assign tx_b = tx_byte(C_DEV_ADR, dat, byte_cnt);
  assign mid  = (qtr == 2'd1) || (qtr == 2'd2);

  i2c_qtic #(
    .C_F_CK  (C_F_CK),
    .C_F_SCL (C_F_SCL)
  ) u_qtic (
    .CK_i    (CK_i),
    .XARST_i (XARST_i),
    .EN_i    (busy),
    .TIC_o   (tic)
  );

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    qtr_n    = qtr;
    bit_n    = bit_cnt;
    byte_n   = byte_cnt;
    scl_c    = 1'b1;
    sda_c    = 1'b1;
    shf_ld   = 1'b0;
    done_set = 1'b0;
    nack_set = 1'b0;
    nack_clr = 1'b0;
    if (tic) qtr_n = qtr + 2'd1;
    unique case (state)
      ST_IDLE: begin
        qtr_n = 2'd0;
        if (pend) begin
          state_n  = ST_START;
          bit_n    = 3'd0;
          byte_n   = 2'd0;
          shf_ld   = 1'b1;
          nack_clr = 1'b1;
        end
      end
      ST_START: begin
        sda_c = (qtr == 2'd0);
        scl_c = (qtr != 2'd3);
        if (tic && qtr == 2'd3) state_n = ST_BIT;
      end
      ST_BIT: begin
        sda_c = tx_b[~bit_cnt];
        scl_c = mid;
        if (tic && qtr == 2'd3) begin
          bit_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = ST_ACK;
        end
      end
      ST_ACK: begin
        scl_c = mid;
        if (tic && qtr == 2'd2 && bus.SDA_i) nack_set = 1'b1;
        // nack_q was cleared at START, so it only reflects this transfer
        if (tic && qtr == 2'd3) begin
          if (nack_q || byte_cnt == LAST_BYTE) begin
            state_n = ST_STOP;
          end else begin
            state_n = ST_BIT;
            byte_n  = byte_cnt + 2'd1;
          end
        end
      end
      ST_STOP: begin
        sda_c = (qtr == 2'd3);
        scl_c = (qtr != 2'd0);
        if (tic && qtr == 2'd3) begin
          state_n  = ST_IDLE;
          done_set = !nack_q;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Line levels are registered: one extra clock of START latency
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      qtr      <= 2'd0;
      bit_cnt  <= 3'd0;
      byte_cnt <= 2'd0;
      dat      <= 12'd0;
      pend     <= 1'b0;
      pend_val <= 12'd0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      qtr      <= qtr_n;
      bit_cnt  <= bit_n;
      byte_cnt <= byte_n;
      scl_q    <= scl_c;
      sda_q    <= sda_c;
      done_q   <= done_set;
      if (nack_clr) begin
        nack_q <= 1'b0;
      end else if (nack_set) begin
        nack_q <= 1'b1;
      end
      if (shf_ld) begin
        dat  <= pend_val;
        pend <= 1'b0;
      end
      // Newest sample wins; a same-cycle load still takes the old one
      if (bus.REQ_i) begin
        pend     <= 1'b1;
        pend_val <= {~bus.WAVEs_i[11], bus.WAVEs_i[10:0]};
      end
    end
  end

  assign bus.SCL_o  = scl_q;
  assign bus.SDA_o  = sda_q;
  assign bus.BUSY_o = busy;
  assign bus.DONE_o = done_q;
  assign bus.NACK_o = nack_q;

endmodule
